wb_regfile: RTL

- Write-back stage and architectural register file of the 5-stage MIPS pipeline.
- Consumes the registered outputs of the MEM/WB pipeline register and selects the write-back data (memory vs ALU).
- Commits that data to a 32-entry register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass, and exports the committed write for EX-stage forwarding.

---
 rtl/wb_regfile.sv | 72 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back stage with 32-entry register file, read bypass and commit record
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [1:0]            WBreg,
    input  logic [DATA_WIDTH-1:0] Memreg,
    input  logic [DATA_WIDTH-1:0] ALUreg,
    input  logic [ADDR_WIDTH-1:0] RegRDreg,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_we,
    output logic                  last_valid,
    output logic [ADDR_WIDTH-1:0] last_addr,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic [31:0]           commit_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign wb_data = WBreg[0] ? Memreg : ALUreg;
    assign wb_we   = WBreg[1] && (RegRDreg != '0);

    // r0 reads as zero even if a stale value were ever present; reset blanks both ports
    always_comb begin
        rs_data = '0;
        if (resetn && (rs_addr != '0)) begin
            if ((BYPASS != 0) && wb_we && (rs_addr == RegRDreg))
                rs_data = wb_data;
            else
                rs_data = regs[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (resetn && (rt_addr != '0)) begin
            if ((BYPASS != 0) && wb_we && (rt_addr == RegRDreg))
                rt_data = wb_data;
            else
                rt_data = regs[rt_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            last_valid   <= 1'b0;
            last_addr    <= '0;
            last_data    <= '0;
            commit_count <= '0;
        end else begin
            last_valid <= wb_we;
            if (wb_we) begin
                regs[RegRDreg] <= wb_data;
                last_addr      <= RegRDreg;
                last_data      <= wb_data;
                commit_count   <= commit_count + 32'd1;
            end
        end
    end

endmodule
